// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizes for the SDRAM command-port arbiter.
// Optional INS starvation promotion is enabled by SDRAM_ARB_STARVE_EN.
package sdram_arb_pkg;

  localparam int ARB_ADDR_W     = 25;
  localparam int ARB_DATA_W     = 16;
  localparam int ARB_BURST_LEN  = 32;
  localparam int ARB_TIMEOUT    = 1024;
  localparam int ARB_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_VGA,
    SRC_DAT,
    SRC_INS
  } arb_src_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Fixed-priority picker VGA > DAT > INS.
// With SDRAM_ARB_STARVE_EN, INS is promoted after STARVE_MAX lost rounds.
module sdram_arb_pick
  import sdram_arb_pkg::*;
`ifdef SDRAM_ARB_STARVE_EN
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX
)
`endif
(
`ifdef SDRAM_ARB_STARVE_EN
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_arb,
`endif
  input  logic     i_vga_req,
  input  logic     i_dat_req,
  input  logic     i_ins_req,
  output logic     o_any,
  output arb_src_t o_src
);

  logic w_promote;
  logic w_sel_v;
  logic w_sel_d;
  logic w_sel_i;

`ifdef SDRAM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);

  logic [SW-1:0] r_starve;

  assign w_promote = i_ins_req && (r_starve == S_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= '0;
    end else if (i_arb) begin
      if (o_src == SRC_INS)
        r_starve <= '0;
      else if (i_ins_req)
        r_starve <= r_starve + 1'b1;
    end
  end
`else
  assign w_promote = 1'b0;
`endif

  // Mask down to a one-hot selection so the decoder below never overlaps
  assign w_sel_v = i_vga_req && !w_promote;
  assign w_sel_d = i_dat_req && !w_promote && !i_vga_req;
  assign w_sel_i = i_ins_req && (w_promote || (!i_vga_req && !i_dat_req));

  always_comb begin
    o_any = 1'b1;
    o_src = SRC_VGA;
    unique case (1'b1)
      w_sel_v: o_src = SRC_VGA;
      w_sel_d: o_src = SRC_DAT;
      w_sel_i: o_src = SRC_INS;
      default: o_any = 1'b0;
    endcase
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the sdram_ctl command port among VGA burst, CPU data and CPU fetch.
// Define SDRAM_ARB_STARVE_EN to enable INS starvation promotion.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int DATA_W      = ARB_DATA_W,
  parameter int BURST_LEN   = ARB_BURST_LEN,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT
`ifdef SDRAM_ARB_STARVE_EN
  , parameter int STARVE_MAX = ARB_STARVE_MAX
`endif
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_vga_req,
  input  logic [ADDR_W-1:0]           i_vga_addr,
  output logic                        o_vga_gnt,
  output logic                        o_vga_done,
  output logic [BURST_LEN*DATA_W-1:0] o_vga_buf,
  input  logic                        i_dat_req,
  input  logic                        i_dat_we,
  input  logic [ADDR_W-1:0]           i_dat_addr,
  input  logic [DATA_W-1:0]           i_dat_wdata,
  output logic                        o_dat_gnt,
  output logic                        o_dat_done,
  output logic [DATA_W-1:0]           o_dat_rdata,
  input  logic                        i_ins_req,
  input  logic [ADDR_W-1:0]           i_ins_addr,
  output logic                        o_ins_gnt,
  output logic                        o_ins_done,
  output logic [DATA_W-1:0]           o_ins_rdata,
  output logic                        o_ctl_write_en,
  output logic [ADDR_W-1:0]           o_ctl_addr,
  output logic [DATA_W-1:0]           o_ctl_data_in,
  output logic                        o_ctl_burst_en,
  output logic                        o_ctl_refresh,
  input  logic                        i_ctl_ready,
  input  logic                        i_ctl_data_ready,
  input  logic [DATA_W-1:0]           i_ctl_data_out,
  input  logic [BURST_LEN*DATA_W-1:0] i_ctl_burst_buf,
  output logic                        o_timeout_err
);

  localparam int BW = BURST_LEN * DATA_W;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  arb_state_t r_state;
  arb_state_t w_next;
  arb_src_t   r_src;
  arb_src_t   w_src;

  logic              w_any;
  logic              w_arb;
  logic              w_tmo;
  logic              w_cap;
  logic              w_tmo_hit;
  logic              w_busy;
  logic [CW-1:0]     r_wait_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_burst;
  logic [DATA_W-1:0] r_dat_rdata;
  logic [DATA_W-1:0] r_ins_rdata;
  logic [BW-1:0]     r_vga_buf;
  logic              r_tmo_err;

  sdram_arb_pick
`ifdef SDRAM_ARB_STARVE_EN
  #(
    .STARVE_MAX (STARVE_MAX)
  )
`endif
  u_pick (
`ifdef SDRAM_ARB_STARVE_EN
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_arb     (w_arb),
`endif
    .i_vga_req (i_vga_req),
    .i_dat_req (i_dat_req),
    .i_ins_req (i_ins_req),
    .o_any     (w_any),
    .o_src     (w_src)
  );

  assign w_arb     = (r_state == IDLE) && i_ctl_ready && w_any;
  assign w_tmo     = (r_wait_cnt == TMO_LAST);
  assign w_cap     = (r_state == WAIT) && i_ctl_data_ready;
  assign w_tmo_hit = (r_state == WAIT) && !i_ctl_data_ready && w_tmo;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_arb) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_cap || w_tmo_hit) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy        = (r_state != IDLE);
    o_ctl_refresh = (r_state == ISSUE);
    o_vga_gnt     = w_busy && (r_src == SRC_VGA);
    o_dat_gnt     = w_busy && (r_src == SRC_DAT);
    o_ins_gnt     = w_busy && (r_src == SRC_INS);
    o_vga_done    = (r_state == DONE) && (r_src == SRC_VGA);
    o_dat_done    = (r_state == DONE) && (r_src == SRC_DAT);
    o_ins_done    = (r_state == DONE) && (r_src == SRC_INS);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_wait_cnt <= '0;
    else if (r_state == WAIT)
      r_wait_cnt <= r_wait_cnt + 1'b1;
    else
      r_wait_cnt <= '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src       <= SRC_VGA;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_burst     <= 1'b0;
      r_dat_rdata <= '0;
      r_ins_rdata <= '0;
      r_vga_buf   <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      if (w_arb) begin
        r_src   <= w_src;
        r_burst <= (w_src == SRC_VGA);
        r_we    <= (w_src == SRC_DAT) && i_dat_we;
        r_wdata <= (w_src == SRC_DAT) ? i_dat_wdata : '0;
        unique case (w_src)
          SRC_VGA: r_addr <= i_vga_addr;
          SRC_DAT: r_addr <= i_dat_addr;
          default: r_addr <= i_ins_addr;
        endcase
      end
      if (w_cap) begin
        unique case (r_src)
          SRC_VGA: r_vga_buf <= i_ctl_burst_buf;
          SRC_DAT: if (!r_we) r_dat_rdata <= i_ctl_data_out;
          default: r_ins_rdata <= i_ctl_data_out;
        endcase
      end
      // Sticky until reset so software can see a controller ever hung
      if (w_tmo_hit)
        r_tmo_err <= 1'b1;
    end
  end

  assign o_ctl_write_en = r_we;
  assign o_ctl_addr     = r_addr;
  assign o_ctl_data_in  = r_wdata;
  assign o_ctl_burst_en = r_burst;
  assign o_dat_rdata    = r_dat_rdata;
  assign o_ins_rdata    = r_ins_rdata;
  assign o_vga_buf      = r_vga_buf;
  assign o_timeout_err  = r_tmo_err;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter with a behavioural sdram_ctl stub.
// Build with SDRAM_ARB_STARVE_EN to also cover INS promotion.
module tb_sdram_arbiter;

  localparam int AW  = 25;
  localparam int DW  = 16;
  localparam int BL  = 32;
  localparam int BW  = BL * DW;
  localparam int TMO = 1024;

  typedef struct {
    int            src;
    logic [BW-1:0] val;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic          vga_done;
  logic [BW-1:0] vga_buf;
  logic          dat_req;
  logic          dat_we;
  logic [AW-1:0] dat_addr;
  logic [DW-1:0] dat_wdata;
  logic          dat_gnt;
  logic          dat_done;
  logic [DW-1:0] dat_rdata;
  logic          ins_req;
  logic [AW-1:0] ins_addr;
  logic          ins_gnt;
  logic          ins_done;
  logic [DW-1:0] ins_rdata;
  logic          ctl_write_en;
  logic [AW-1:0] ctl_addr;
  logic [DW-1:0] ctl_data_in;
  logic          ctl_burst_en;
  logic          ctl_refresh;
  logic          ctl_ready;
  logic          ctl_data_ready;
  logic [DW-1:0] ctl_data_out;
  logic [BW-1:0] ctl_burst_buf;
  logic          timeout_err;

  logic          stub_hang;
  logic          ready_block;
  logic          keep_vga;
  logic          st_busy;
  int            st_cnt;
  logic [DW-1:0] mem [0:1023];

  exp_t sb[$];
  int   n_chk;
  int   n_err;
  int   n_done;
  int   cyc;
  int   ref_cyc;
  int   done_cyc;
  int   rdy_cyc;

  sdram_arbiter dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_vga_req        (vga_req),
    .i_vga_addr       (vga_addr),
    .o_vga_gnt        (vga_gnt),
    .o_vga_done       (vga_done),
    .o_vga_buf        (vga_buf),
    .i_dat_req        (dat_req),
    .i_dat_we         (dat_we),
    .i_dat_addr       (dat_addr),
    .i_dat_wdata      (dat_wdata),
    .o_dat_gnt        (dat_gnt),
    .o_dat_done       (dat_done),
    .o_dat_rdata      (dat_rdata),
    .i_ins_req        (ins_req),
    .i_ins_addr       (ins_addr),
    .o_ins_gnt        (ins_gnt),
    .o_ins_done       (ins_done),
    .o_ins_rdata      (ins_rdata),
    .o_ctl_write_en   (ctl_write_en),
    .o_ctl_addr       (ctl_addr),
    .o_ctl_data_in    (ctl_data_in),
    .o_ctl_burst_en   (ctl_burst_en),
    .o_ctl_refresh    (ctl_refresh),
    .i_ctl_ready      (ctl_ready),
    .i_ctl_data_ready (ctl_data_ready),
    .i_ctl_data_out   (ctl_data_out),
    .i_ctl_burst_buf  (ctl_burst_buf),
    .o_timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 1)
      return 16'h0009;
    else if (i >= 32 && i < 64)
      return DW'(16'h111 * (i - 32));
    else
      return DW'(i);
  endfunction

  assign ctl_ready = !st_busy && !ready_block;

  // sdram_ctl stand-in: fixed-plus-random latency, 1k-word memory
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_busy        <= 1'b0;
      st_cnt         <= 0;
      ctl_data_ready <= 1'b0;
      ctl_data_out   <= '0;
      ctl_burst_buf  <= '0;
      for (int i = 0; i < 1024; i++)
        mem[i] <= init_val(i);
    end else begin
      ctl_data_ready <= 1'b0;
      if (ctl_refresh && !st_busy) begin
        st_busy <= 1'b1;
        st_cnt  <= 2 + int'($urandom_range(0, 3));
      end else if (st_busy && !stub_hang) begin
        if (st_cnt == 0) begin
          st_busy        <= 1'b0;
          ctl_data_ready <= 1'b1;
          if (ctl_write_en)
            mem[ctl_addr[9:0]] <= ctl_data_in;
          else
            ctl_data_out <= mem[ctl_addr[9:0]];
          for (int i = 0; i < BL; i++)
            ctl_burst_buf[i*DW +: DW] <= mem[10'(ctl_addr[9:0] + 10'(i))];
        end else begin
          st_cnt <= st_cnt - 1;
        end
      end
    end
  end

  task automatic chk(string tag, logic [BW-1:0] got, logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(int src, logic [BW-1:0] val);
    exp_t e;
    e.src = src;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    int   ng;
    int   nd;
    int   src;
    exp_t e;
    @(negedge clk);
    cyc++;
    ng = int'(vga_gnt) + int'(dat_gnt) + int'(ins_gnt);
    nd = int'(vga_done) + int'(dat_done) + int'(ins_done);
    chk("gnt_onehot", BW'(ng <= 1), BW'(1));
    if (ctl_data_ready && ng == 1)
      rdy_cyc = cyc;
    if (ctl_refresh) begin
      if (rdy_cyc > 0)
        chk("rdy_to_refresh", BW'((cyc - rdy_cyc) >= 3), BW'(1));
      ref_cyc = cyc;
    end
    if (nd != 0) begin
      n_done++;
      done_cyc = cyc;
      chk("done_onehot", BW'(nd), BW'(1));
      src = vga_done ? 0 : (dat_done ? 1 : 2);
      if (sb.size() == 0) begin
        chk("unexpected_done", BW'(src), BW'(99));
      end else begin
        e = sb.pop_front();
        chk("done_src", BW'(src), BW'(e.src));
        chk("done_gnt", BW'({vga_gnt, dat_gnt, ins_gnt}), BW'(3'b100 >> e.src));
        if (e.src == 0)
          chk("vga_buf", vga_buf, e.val);
        else if (e.src == 1)
          chk("dat_rdata", BW'(dat_rdata), e.val);
        else
          chk("ins_rdata", BW'(ins_rdata), e.val);
      end
      if (ins_done && keep_vga) begin
        keep_vga = 1'b0;
        vga_req  = 1'b0;
      end
      if (vga_done && !keep_vga) vga_req = 1'b0;
      if (dat_done) dat_req = 1'b0;
      if (ins_done) ins_req = 1'b0;
    end
  endtask

  task automatic drain(int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain_left", BW'(sb.size()), BW'(0));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_flags"},
        BW'({vga_gnt, dat_gnt, ins_gnt, vga_done, dat_done, ins_done,
             ctl_write_en, ctl_burst_en, ctl_refresh, timeout_err}),
        BW'(0));
    chk({tag, "_addr"}, BW'(ctl_addr), BW'(0));
    chk({tag, "_wdata"}, BW'(ctl_data_in), BW'(0));
    chk({tag, "_rdata"}, BW'({dat_rdata, ins_rdata}), BW'(0));
    chk({tag, "_vbuf"}, vga_buf, BW'(0));
  endtask

  function automatic logic [BW-1:0] burst_at(int base);
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < BL; i++)
      b[i*DW +: DW] = init_val(base + i);
    return b;
  endfunction

  initial begin
    int k;
    int nd0;
    n_chk       = 0;
    n_err       = 0;
    n_done      = 0;
    cyc         = 0;
    ref_cyc     = 0;
    done_cyc    = 0;
    rdy_cyc     = 0;
    rst_n       = 1'b0;
    stub_hang   = 1'b0;
    ready_block = 1'b0;
    keep_vga    = 1'b0;
    vga_req     = 1'b0;
    vga_addr    = '0;
    dat_req     = 1'b0;
    dat_we      = 1'b0;
    dat_addr    = '0;
    dat_wdata   = '0;
    ins_req     = 1'b0;
    ins_addr    = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // single fetch
    push(2, BW'(16'h0009));
    ins_addr = AW'(1);
    ins_req  = 1'b1;
    drain(200);

    // write then read back
    push(1, BW'(0));
    dat_we    = 1'b1;
    dat_addr  = '0;
    dat_wdata = 16'hABAB;
    dat_req   = 1'b1;
    drain(200);
    chk("mem0_written", BW'(mem[0]), BW'(16'hABAB));
    push(1, BW'(16'hABAB));
    dat_we  = 1'b0;
    dat_req = 1'b1;
    drain(200);

    // three simultaneous requests: VGA, DAT, INS order
    push(0, burst_at(64));
    push(1, BW'(16'h0005));
    push(2, BW'(16'h0009));
    vga_addr = AW'(64);
    dat_addr = AW'(5);
    ins_addr = AW'(1);
    vga_req  = 1'b1;
    dat_req  = 1'b1;
    ins_req  = 1'b1;
    drain(500);

    // burst with 12'h111*i pattern
    push(0, burst_at(32));
    vga_addr = {6'h1, 9'd7, 10'd32};
    vga_req  = 1'b1;
    drain(200);

    // controller not ready: no grant until released
    ready_block = 1'b1;
    dat_addr    = AW'(3);
    dat_req     = 1'b1;
    repeat (10) tick();
    chk("no_gnt_unready", BW'(dat_gnt), BW'(0));
    push(1, BW'(16'h0003));
    ready_block = 1'b0;
    drain(200);

    // controller hangs: abort after TMO WAIT cycles, rdata kept
    stub_hang = 1'b1;
    push(2, BW'(16'h0009));
    ins_addr = AW'(2);
    ins_req  = 1'b1;
    drain(TMO + 200);
    chk("tmo_err", BW'(timeout_err), BW'(1));
    chk("tmo_len", BW'(done_cyc - ref_cyc), BW'(TMO + 1));
    stub_hang = 1'b0;
    push(1, BW'(16'h0002));
    dat_addr = AW'(2);
    dat_req  = 1'b1;
    drain(200);
    chk("tmo_sticky", BW'(timeout_err), BW'(1));

    // async reset in the middle of WAIT
    stub_hang = 1'b1;
    ins_addr  = AW'(1);
    ins_req   = 1'b1;
    k = 0;
    while (!ctl_refresh && k < 50) begin
      tick();
      k++;
    end
    chk("refresh_seen", BW'(ctl_refresh), BW'(1));
    repeat (3) tick();
    nd0 = n_done;
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    ins_req   = 1'b0;
    stub_hang = 1'b0;
    repeat (4) tick();
    chk("no_done_reset", BW'(n_done), BW'(nd0));
    rst_n   = 1'b1;
    rdy_cyc = 0;
    tick();

`ifdef SDRAM_ARB_STARVE_EN
    // INS promoted on the fifth arbitration under constant VGA load
    for (int i = 0; i < 4; i++)
      push(0, burst_at(64));
    push(2, BW'(16'h0009));
    keep_vga = 1'b1;
    vga_addr = AW'(64);
    ins_addr = AW'(1);
    vga_req  = 1'b1;
    ins_req  = 1'b1;
    drain(800);
`endif

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
